dmx_frame_sequencer: RTL and testbench



---
 rtl/dmx_frame_sequencer_if.sv | 22 ++
 rtl/dmx_frame_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_dmx_frame_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmx_frame_sequencer_if.sv
// Classic Wishbone link between the DMX frame sequencer (master) and the
// 16550-compatible UART register port (slave). Byte-wide data on lane 0.
interface dmx_frame_sequencer_if;
   logic       wb_cyc;
   logic       wb_stb;
   logic       wb_we;
   logic [2:0] wb_addr;
   logic [7:0] wb_wdata;
   logic [3:0] wb_sel;
   logic [7:0] wb_rdata;
   logic       wb_ack;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
      input  wb_rdata, wb_ack
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
      output wb_rdata, wb_ack
   );
endinterface

// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame sequencer: programs a 16550 UART after reset, then on each
// start emits break, mark-after-break, start code and up to 512 slot bytes
// fetched from an external slot RAM, all through single Wishbone transfers.
module dmx_frame_sequencer #(
   parameter int unsigned DIVISOR      = 12,
   parameter int unsigned BREAK_CYCLES = 4800,
   parameter int unsigned MAB_CYCLES   = 576,
   parameter int unsigned ACK_TIMEOUT  = 255
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [9:0]                   slot_count,
   input  logic [7:0]                   start_code,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         slot_rd,
   output logic [8:0]                   slot_addr,
   input  logic [7:0]                   slot_data,
   dmx_frame_sequencer_if.master        wb
);

   localparam int unsigned TO_W     = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned WAIT_MAX = (BREAK_CYCLES > MAB_CYCLES) ? BREAK_CYCLES : MAB_CYCLES;
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

   localparam logic [15:0] DIV_LATCH = 16'(DIVISOR);

   localparam logic [2:0] REG_THR = 3'd0;  // also DLL when DLAB=1
   localparam logic [2:0] REG_DLM = 3'd1;
   localparam logic [2:0] REG_FCR = 3'd2;
   localparam logic [2:0] REG_LCR = 3'd3;
   localparam logic [2:0] REG_MCR = 4'd4;
   localparam logic [2:0] REG_LSR = 3'd5;

   typedef enum logic [3:0] {
      ST_INIT, ST_IDLE, ST_BREAK, ST_BRK_WAIT, ST_MAB, ST_MAB_WAIT,
      ST_POLL, ST_FETCH, ST_SLOT, ST_LOAD, ST_THR, ST_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [2:0]        addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [2:0]        init_idx_q, init_idx_d;
   logic [9:0]        byte_idx_q, byte_idx_d;
   logic [4:0]        burst_q, burst_d;
   logic [9:0]        count_q, count_d;
   logic [7:0]        code_q, code_d;
   logic              slot_rd_q, slot_rd_d;
   logic [8:0]        slot_addr_q, slot_addr_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              ack_ok;
   logic              unused_rdata;

   // Register writes issued after reset, as {address, data}.
   function automatic logic [10:0] init_entry(input logic [2:0] idx);
      case (idx)
         3'd0:    init_entry = {REG_LCR, 8'h83};
         3'd1:    init_entry = {REG_THR, DIV_LATCH[7:0]};
         3'd2:    init_entry = {REG_DLM, DIV_LATCH[15:8]};
         3'd3:    init_entry = {REG_LCR, 8'h07};
         3'd4:    init_entry = {REG_FCR, 8'h07};
         default: init_entry = {REG_MCR, 8'h03};
      endcase
   endfunction

   // Next-state, bus launch/acknowledge handling and ack timeout.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      to_cnt_d    = '0;
      wait_d      = wait_q;
      init_idx_d  = init_idx_q;
      byte_idx_d  = byte_idx_q;
      burst_d     = burst_q;
      count_d     = count_q;
      code_d      = code_q;
      slot_rd_d   = 1'b0;
      slot_addr_d = slot_addr_q;
      done_d      = 1'b0;
      err_d       = err_q;

      ack_ok = cyc_q & wb.wb_ack;
      if (cyc_q && !wb.wb_ack) to_cnt_d = to_cnt_q + 1'b1;
      // cyc/stb drop the cycle after ack; launches only happen with cyc low,
      // which yields the mandatory idle cycle between transfers.
      if (ack_ok) cyc_d = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               {addr_d, wdata_d} = init_entry(init_idx_q);
            end else if (ack_ok) begin
               if (init_idx_q == 3'd5) begin
                  init_idx_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  init_idx_d = init_idx_q + 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (start) begin
               count_d    = (slot_count > 10'd512) ? 10'd512 : slot_count;
               code_d     = start_code;
               err_d      = 1'b0;
               byte_idx_d = '0;
               cyc_d      = 1'b1;
               we_d       = 1'b1;
               addr_d     = REG_LCR;
               wdata_d    = 8'h47;
               state_d    = ST_BREAK;
            end
         end
         ST_BREAK: begin
            if (ack_ok) begin
               wait_d  = '0;
               state_d = ST_BRK_WAIT;
            end
         end
         ST_BRK_WAIT: begin
            if (wait_q == WAIT_W'(BREAK_CYCLES - 1)) begin
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = REG_LCR;
               wdata_d = 8'h07;
               state_d = ST_MAB;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_MAB: begin
            if (ack_ok) begin
               wait_d  = '0;
               state_d = ST_MAB_WAIT;
            end
         end
         ST_MAB_WAIT: begin
            if (wait_q == WAIT_W'(MAB_CYCLES - 1)) begin
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = REG_LSR;
               state_d = ST_POLL;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_POLL: begin
            if (!cyc_q) begin
               cyc_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = REG_LSR;
            end else if (ack_ok && wb.wb_rdata[5]) begin
               burst_d = 5'd16;
               state_d = (byte_idx_q == '0) ? ST_LOAD : ST_FETCH;
            end
         end
         ST_FETCH: begin
            slot_rd_d   = 1'b1;
            slot_addr_d = 9'(byte_idx_q - 10'd1);
            state_d     = ST_SLOT;
         end
         ST_SLOT: begin
            // slot_rd is on the RAM this cycle; data follows next cycle
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = REG_THR;
            wdata_d = (byte_idx_q == '0) ? code_q : slot_data;
            state_d = ST_THR;
         end
         ST_THR: begin
            if (ack_ok) begin
               byte_idx_d = byte_idx_q + 1'b1;
               burst_d    = burst_q - 1'b1;
               if (byte_idx_q == count_q) state_d = ST_DRAIN;
               else if (burst_q == 5'd1)  state_d = ST_POLL;
               else                       state_d = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (!cyc_q) begin
               cyc_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = REG_LSR;
            end else if (ack_ok && wb.wb_rdata[6]) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase

      if (cyc_q && !wb.wb_ack && to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
         cyc_d    = 1'b0;
         to_cnt_d = '0;
         err_d    = 1'b1;
         state_d  = ST_IDLE;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         to_cnt_q    <= '0;
         wait_q      <= '0;
         init_idx_q  <= '0;
         byte_idx_q  <= '0;
         burst_q     <= '0;
         count_q     <= '0;
         code_q      <= '0;
         slot_rd_q   <= 1'b0;
         slot_addr_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         to_cnt_q    <= to_cnt_d;
         wait_q      <= wait_d;
         init_idx_q  <= init_idx_d;
         byte_idx_q  <= byte_idx_d;
         burst_q     <= burst_d;
         count_q     <= count_d;
         code_q      <= code_d;
         slot_rd_q   <= slot_rd_d;
         slot_addr_q <= slot_addr_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign wb.wb_cyc   = cyc_q;
   assign wb.wb_stb   = cyc_q;
   assign wb.wb_we    = we_q;
   assign wb.wb_addr  = addr_q;
   assign wb.wb_wdata = wdata_q;
   assign wb.wb_sel   = 4'b0001;

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign slot_rd   = slot_rd_q;
   assign slot_addr = slot_addr_q;

   // Only THRE and TEMT of LSR are consulted.
   assign unused_rdata = ^{wb.wb_rdata[7], wb.wb_rdata[4:0]};

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Bench for dmx_frame_sequencer: UART register/FIFO model as Wishbone slave,
// slot RAM model, and a frame-level reference of expected bus traffic.
`timescale 1ns/1ps
module tb_dmx_frame_sequencer;
   localparam int unsigned BREAK_CYCLES = 4800;
   localparam int unsigned MAB_CYCLES   = 576;
   localparam int unsigned ACK_TIMEOUT  = 255;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] slot_count = '0;
   logic [7:0] start_code = '0;
   logic       busy, done, err, slot_rd;
   logic [8:0] slot_addr;
   logic [7:0] slot_data = '0;

   dmx_frame_sequencer_if wb ();

   dmx_frame_sequencer #(
      .DIVISOR(12), .BREAK_CYCLES(BREAK_CYCLES),
      .MAB_CYCLES(MAB_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .slot_count(slot_count),
      .start_code(start_code), .busy(busy), .done(done), .err(err),
      .slot_rd(slot_rd), .slot_addr(slot_addr), .slot_data(slot_data),
      .wb(wb.master)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [7:0]  data;
      int unsigned t;
   } xfer_t;

   function automatic logic [11:0] pack(input xfer_t x);
      return {x.we, x.addr, x.data};
   endfunction

   int unsigned cyc_no = 0;
   xfer_t       xlog[$];
   int unsigned slot_log[$];
   int unsigned done_cnt = 0;

   // Bus / slot-read / done monitor
   always @(posedge clk) begin
      cyc_no <= cyc_no + 1;
      if (wb.wb_cyc && wb.wb_stb && wb.wb_ack)
         xlog.push_back('{wb.wb_we, wb.wb_addr, wb.wb_we ? wb.wb_wdata : wb.wb_rdata, cyc_no});
      if (slot_rd) slot_log.push_back(int'(slot_addr));
      if (done) done_cnt <= done_cnt + 1;
   end

   // UART slave: ack latency, LCR/DLAB, 16-byte TX FIFO drained 8 clk per byte
   logic [1:0]  lat = '0;
   logic [1:0]  wcnt = '0;
   logic        rand_lat = 1'b0;
   logic        no_ack = 1'b0;
   logic [7:0]  lcr = '0;
   int          fifo_cnt = 0;
   logic        shifting = 1'b0;
   int unsigned sh_tmr = 0;
   int unsigned overflows = 0;
   logic        thre, temt;

   assign thre = (fifo_cnt == 0);
   assign temt = thre && !shifting;
   assign wb.wb_ack   = wb.wb_cyc && wb.wb_stb && !no_ack && (wcnt == lat);
   assign wb.wb_rdata = (wb.wb_addr == 3'd5) ? {1'b0, temt, thre, 5'b0} : 8'h00;

   always @(posedge clk) begin : uart_model
      int push;
      int pop;
      push = 0;
      pop  = 0;
      if (wb.wb_cyc && wb.wb_stb && !wb.wb_ack) wcnt <= wcnt + 1'b1;
      else                                       wcnt <= '0;
      if (wb.wb_ack) begin
         lat <= rand_lat ? 2'($urandom_range(0, 2)) : 2'd0;
         if (wb.wb_we && wb.wb_addr == 3'd3) lcr <= wb.wb_wdata;
         if (wb.wb_we && wb.wb_addr == 3'd0 && !lcr[7]) push = 1;
      end
      if (shifting) begin
         if (sh_tmr == 7) shifting <= 1'b0;
         sh_tmr <= sh_tmr + 1;
      end else if (fifo_cnt > 0) begin
         pop = 1;
         shifting <= 1'b1;
         sh_tmr <= 0;
      end
      if (push == 1 && fifo_cnt - pop >= 16) overflows <= overflows + 1;
      fifo_cnt <= fifo_cnt + push - pop;
   end

   // Slot RAM: data valid only the cycle after slot_rd, garbage otherwise
   logic [7:0] ram [512];
   always @(posedge clk) slot_data <= slot_rd ? ram[slot_addr] : 8'($urandom);

   logic [11:0] exp_init [6] = '{
      {1'b1, 3'd3, 8'h83}, {1'b1, 3'd0, 8'h0C}, {1'b1, 3'd1, 8'h00},
      {1'b1, 3'd3, 8'h07}, {1'b1, 3'd2, 8'h07}, {1'b1, 3'd4, 8'h03}
   };

   task automatic check_init();
      int unsigned w;
      for (w = 0; w < 2000 && busy; w++) @(negedge clk);
      check_eq("init_busy_fall", busy, 1'b0);
      check_eq("init_len", xlog.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < xlog.size()) check_eq("init_wr", pack(xlog[i]), exp_init[i]);
   endtask

   task automatic run_frame(input int unsigned n, input logic [7:0] sc,
                            input bit fixed_ram, input bit poke_start);
      int unsigned nslots, total, p, k, b, waited, idle_hi;
      bit          got_done;
      int unsigned bursts[$];
      logic [7:0]  exp_bytes[$];

      nslots = (n > 512) ? 512 : n;
      for (int i = 0; i < 512; i++) ram[i] = fixed_ram ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      exp_bytes.push_back(sc);
      for (int i = 0; i < int'(nslots); i++) exp_bytes.push_back(ram[i]);
      total = nslots + 1;
      k = total;
      while (k > 0) begin
         b = (k > 16) ? 16 : k;
         bursts.push_back(b);
         k -= b;
      end

      @(negedge clk);
      xlog.delete();
      slot_log.delete();
      done_cnt = 0;
      slot_count = 10'(n);
      start_code = sc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("start_to_stb", {wb.wb_stb, wb.wb_addr, wb.wb_wdata}, {1'b1, 3'd3, 8'h47});
      check_eq("err_clr", err, 1'b0);
      check_eq("busy_accept", busy, 1'b1);

      got_done = 1'b0;
      for (waited = 0; waited < 30000 && !got_done; waited++) begin
         @(negedge clk);
         start = (poke_start && waited == 200) ? 1'b1 : 1'b0;
         if (done) got_done = 1'b1;
      end
      start = 1'b0;
      check_eq("done_seen", got_done, 1'b1);
      check_eq("busy_at_done", busy, 1'b0);
      @(negedge clk);
      check_eq("done_width", done, 1'b0);
      check_eq("done_count", done_cnt, 1);
      check_eq("err_frame", err, 1'b0);

      if (xlog.size() < 4) begin
         check_eq("log_short", xlog.size(), 4);
         return;
      end
      check_eq("brk_lcr", pack(xlog[0]), {1'b1, 3'd3, 8'h47});
      check_eq("mab_lcr", pack(xlog[1]), {1'b1, 3'd3, 8'h07});
      check_eq("brk_len_ok", (xlog[1].t - xlog[0].t) >= BREAK_CYCLES, 1'b1);

      p = 2;
      k = 0;
      foreach (bursts[bi]) begin
         while (p < xlog.size() && !xlog[p].we && xlog[p].addr == 3'd5 && !xlog[p].data[5]) p++;
         if (p >= xlog.size()) begin
            check_eq("poll_missing", p, xlog.size() - 1);
            break;
         end
         check_eq("poll_thre", {xlog[p].we, xlog[p].addr, xlog[p].data[5]}, {1'b0, 3'd5, 1'b1});
         p++;
         b = 0;
         while (p < xlog.size() && xlog[p].we && xlog[p].addr == 3'd0) begin
            if (k < exp_bytes.size()) check_eq("thr_data", xlog[p].data, exp_bytes[k]);
            if (k == 0) check_eq("mab_len_ok", (xlog[p].t - xlog[1].t) >= MAB_CYCLES, 1'b1);
            k++;
            b++;
            p++;
         end
         check_eq("burst_len", b, bursts[bi]);
      end
      check_eq("thr_total", k, total);
      while (p < xlog.size() && !xlog[p].we && xlog[p].addr == 3'd5 && !xlog[p].data[6]) p++;
      if (p < xlog.size()) begin
         check_eq("drain_temt", {xlog[p].we, xlog[p].addr, xlog[p].data[6]}, {1'b0, 3'd5, 1'b1});
         check_eq("drain_last", xlog.size() - p, 1);
      end else begin
         check_eq("drain_missing", p, xlog.size() - 1);
      end

      check_eq("slot_cnt", slot_log.size(), nslots);
      foreach (slot_log[i]) check_eq("slot_addr", slot_log[i], i);

      idle_hi = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wb.wb_cyc) idle_hi++;
      end
      check_eq("no_second_frame", idle_hi, 0);
      check_eq("idle_busy", busy, 1'b0);
   endtask

   initial begin : watchdog
      #1500us;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned hi, w;
      bit          seen_thr;

      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_bus", {wb.wb_cyc, wb.wb_stb, wb.wb_we, wb.wb_addr, wb.wb_wdata}, '0);
      check_eq("rst_slot", {slot_rd, slot_addr}, '0);
      check_eq("rst_flags", {done, err}, '0);
      check_eq("rst_busy", busy, 1'b1);
      check_eq("rst_sel", wb.wb_sel, 4'b0001);
      xlog.delete();
      reset_n = 1'b1;
      check_init();

      run_frame(3, 8'h00, 1'b1, 1'b0);
      rand_lat = 1'b1;
      run_frame(40, 8'($urandom), 1'b0, 1'b0);
      run_frame(600, 8'($urandom), 1'b0, 1'b0);
      run_frame(0, 8'($urandom), 1'b0, 1'b0);

      // slave never acks the BREAK write
      no_ack = 1'b1;
      @(negedge clk);
      done_cnt = 0;
      slot_count = 10'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hi = 0;
      for (int i = 0; i < 1000; i++) begin
         if (wb.wb_stb) hi++;
         else if (hi > 0) break;
         @(negedge clk);
      end
      check_eq("to_stb_len", hi, ACK_TIMEOUT);
      check_eq("to_err", err, 1'b1);
      check_eq("to_busy", busy, 1'b0);
      repeat (20) @(negedge clk);
      check_eq("to_err_sticky", err, 1'b1);
      check_eq("to_no_done", done_cnt, 0);
      no_ack = 1'b0;
      run_frame(17, 8'($urandom), 1'b0, 1'b0);

      run_frame(10, 8'($urandom), 1'b0, 1'b1);

      // reset in the middle of FILL, while a transfer is outstanding
      @(negedge clk);
      xlog.delete();
      done_cnt = 0;
      slot_count = 10'd30;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen_thr = 1'b0;
      for (w = 0; w < 20000 && !seen_thr; w++) begin
         @(negedge clk);
         foreach (xlog[i]) if (i >= 2 && xlog[i].we && xlog[i].addr == 3'd0) seen_thr = 1'b1;
      end
      check_eq("rst_fill_reached", seen_thr, 1'b1);
      for (w = 0; w < 100 && !wb.wb_cyc; w++) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_eq("rst_cyc_drop", {wb.wb_cyc, wb.wb_stb}, 2'b00);
      check_eq("rst_busy_mid", busy, 1'b1);
      xlog.delete();
      reset_n = 1'b1;
      check_init();
      check_eq("rst_no_done", done_cnt, 0);

      run_frame($urandom_range(1, 60), 8'($urandom), 1'b0, 1'b0);
      run_frame($urandom_range(1, 60), 8'($urandom), 1'b0, 1'b0);

      check_eq("fifo_overflow", overflows, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
